hazard_ctrl_unit: RTL and testbench
===================================

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising edge) and reset input 1 (synchronous, active-high).
REQ-002 SHALL have these decode-side ports: id_rs input 5 (ID source A); id_rt input 5 (ID source B); id_uses_rt input 1 (ID reads rt).
REQ-003 SHALL have these EX-side ports: ex_rs input 5; ex_rt input 5; ex_rd input 5; ex_RegWrite input 1; ex_MemRead input 1.
REQ-004 SHALL have these MEM/WB-side ports: mem_rd input 5; mem_RegWrite input 1; wb_rd input 5; wb_RegWrite input 1.
REQ-005 SHALL have these redirect and memory ports: branch_taken input 1 (branch resolved taken in MEM); jump_taken input 1 (same); dmem_req input 1 (MEM access active); dmem_ready input 1 (data memory done).
REQ-006 SHALL drive these outputs: pc_stall 1; ifid_stall 1; ifid_flush 1; idex_stall 1; idex_flush 1; exmem_stall 1; exmem_flush 1; memwb_stall 1; memwb_flush 1.
REQ-007 SHALL drive these status outputs: fwd_a output 2; fwd_b output 2 (00 register file, 10 EX/MEM, 01 MEM/WB); stall_cnt output 16 (saturating count of stall cycles).

Function
REQ-008 SHALL keep a registered FSM with states S_RUN, S_MEMWAIT and S_REDIRECT; control outputs SHALL be combinational from state and inputs, with zero-cycle latency.
REQ-009 In S_RUN, dmem_req=1 with dmem_ready=0 SHALL assert pc_stall, ifid_stall, idex_stall, exmem_stall and memwb_flush, and SHALL go to S_MEMWAIT.
REQ-010 S_MEMWAIT SHALL hold the REQ-009 outputs each cycle dmem_ready=0; on dmem_ready=1 it SHALL release all stalls that cycle and return to S_RUN.
REQ-011 In S_RUN with no memory wait, branch_taken or jump_taken SHALL assert ifid_flush, idex_flush and exmem_flush for one cycle and go to S_REDIRECT.
REQ-012 S_REDIRECT SHALL ignore data hazards for one cycle and SHALL return to S_RUN unconditionally, unless a memory wait occurs (REQ-009 applies).
REQ-013 Priority SHALL be: memory wait > redirect > data-hazard stall; flush outputs SHALL override stall outputs of the same register.
REQ-014 On a data hazard, the block SHALL assert pc_stall, ifid_stall and idex_flush; a data hazard SHALL never stall EX/MEM or MEM/WB.
REQ-015 Register 0 SHALL never cause a hazard or a forward; id_rt SHALL be compared only when id_uses_rt=1.
REQ-016 stall_cnt SHALL increment by one each cycle pc_stall=1 and SHALL saturate at 16'hFFFF.
REQ-017 Simultaneous branch_taken and dmem_req&!dmem_ready SHALL take the memory wait; the branch SHALL be honoured on the release cycle because the MEM inputs are held.

Reset
REQ-018 On reset, state SHALL be S_RUN and stall_cnt SHALL be 0.
REQ-019 While reset=1, all stall and flush outputs SHALL be 0 and fwd_a/fwd_b SHALL be 00.
REQ-020 Reset mid-S_MEMWAIT SHALL abandon the wait; the block SHALL be in S_RUN on the next cycle.

Configuration
REQ-021 Macro FORWARDING_EN defined: a hazard SHALL be load-use only (ex_MemRead=1 and ex_rd matches a used ID source), a one-cycle stall.
REQ-022 Macro FORWARDING_EN defined: fwd_a/fwd_b SHALL select 10 when ex_rs/ex_rt matches mem_rd with mem_RegWrite, else 01 on a wb_rd match with wb_RegWrite, else 00.
REQ-023 Macro FORWARDING_EN undefined: a hazard SHALL be any ID source matching ex_rd (ex_RegWrite) or mem_rd (mem_RegWrite), and fwd_a/fwd_b SHALL be tied 00.
REQ-024 Macro FORWARDING_EN undefined: the register file is write-first, so WB SHALL not be a hazard source.

Structure
REQ-025 Shared package hazard_pkg SHALL hold the fwd_sel_t enum (FWD_RF, FWD_MEMWB, FWD_EXMEM) and the state enum hz_state_t.
REQ-026 Forwarding-select logic SHALL be sub-module forwarding_unit, instantiated only under FORWARDING_EN.

Verification
REQ-027 Load-use: ex_MemRead=1, ex_rd=8, id_rs=8 -> pc_stall=1, ifid_stall=1, idex_flush=1 for exactly one cycle (FORWARDING_EN).
REQ-028 Forward: ex_rs=5, mem_rd=5, mem_RegWrite=1, wb_rd=5, wb_RegWrite=1 -> fwd_a=10; set mem_RegWrite=0 -> fwd_a=01.
REQ-029 Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> 3 cycles of stalls plus memwb_flush, release on the 4th cycle, stall_cnt=3.
REQ-030 Branch: branch_taken=1 in S_RUN -> ifid/idex/exmem flush=1 for one cycle, then S_REDIRECT, then S_RUN.
REQ-031 Collision: branch_taken=1 with dmem_req=1, dmem_ready=0 -> stall only; flushes on the dmem_ready cycle.
REQ-032 Reset mid-wait: reset=1 during S_MEMWAIT -> all outputs 0, stall_cnt=0, next state S_RUN; id_rs=0 with ex_rd=0 -> no stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Holds the forwarding-select enum, the controller state enum, the packed
// control-output bundle and a register-match helper.
package hazard_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [FWD_W-1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        S_RUN      = 2'b00,
        S_MEMWAIT  = 2'b01,
        S_REDIRECT = 2'b10
    } hz_state_t;

    // Per-register pipeline control bundle.
    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_stall;
        logic idex_flush;
        logic exmem_stall;
        logic exmem_flush;
        logic memwb_stall;
        logic memwb_flush;
    } hz_ctrl_t;

    // Register 0 is hard-wired zero, so it never matches anything.
    function automatic logic reg_match(input logic [REG_W-1:0] a,
                                       input logic [REG_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/forwarding_unit.sv
// EX-stage operand forwarding select.
// Ports: ex_rs/ex_rt   - EX source registers
//        mem_rd/mem_RegWrite, wb_rd/wb_RegWrite - in-flight writers
//        fwd_a/fwd_b   - operand source select (EX/MEM beats MEM/WB beats RF)
module forwarding_unit
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_RegWrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_RegWrite,
    output fwd_sel_t         fwd_a,
    output fwd_sel_t         fwd_b
);

    function automatic fwd_sel_t pick(input logic [REG_W-1:0] src,
                                      input logic [REG_W-1:0] m_rd,
                                      input logic             m_we,
                                      input logic [REG_W-1:0] w_rd,
                                      input logic             w_we);
        if (m_we && reg_match(src, m_rd))      return FWD_EXMEM;
        else if (w_we && reg_match(src, w_rd)) return FWD_MEMWB;
        else                                   return FWD_RF;
    endfunction

    always_comb begin
        fwd_a = pick(ex_rs, mem_rd, mem_RegWrite, wb_rd, wb_RegWrite);
        fwd_b = pick(ex_rt, mem_rd, mem_RegWrite, wb_rd, wb_RegWrite);
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Five-stage pipeline hazard controller: memory-wait stalls, branch/jump
// redirect flushes, data-hazard interlock, operand forwarding selects and a
// saturating stall-cycle counter. Control outputs are combinational from
// state and inputs; only the state and stall_cnt are registered.
// Config macro: FORWARDING_EN - enables forwarding (load-use interlock only);
//               when undefined, any pending EX/MEM write to an ID source stalls.
// Ports: clk, reset (sync, active-high); id_* decode sources; ex_*/mem_*/wb_*
//        pipeline writer info; branch_taken/jump_taken redirects; dmem_req/
//        dmem_ready data memory handshake; *_stall/*_flush per-register
//        controls; fwd_a/fwd_b forward selects; stall_cnt stall-cycle count.
module hazard_ctrl_unit
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_RegWrite,
    input  logic             ex_MemRead,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_RegWrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_RegWrite,
    input  logic             branch_taken,
    input  logic             jump_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_stall,
    output logic             exmem_flush,
    output logic             memwb_stall,
    output logic             memwb_flush,
    output logic [FWD_W-1:0] fwd_a,
    output logic [FWD_W-1:0] fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    hz_state_t state;
    hz_state_t state_next;
    hz_ctrl_t  ctrl;
    logic      mem_wait;
    logic      redirect;
    logic      data_hazard;

    assign mem_wait = dmem_req && !dmem_ready;
    assign redirect = branch_taken || jump_taken;

`ifdef FORWARDING_EN
    fwd_sel_t fwd_a_sel;
    fwd_sel_t fwd_b_sel;
    logic     unused_ok;

    // With forwarding only a load result still in EX cannot be bypassed.
    assign data_hazard = ex_MemRead &&
                         (reg_match(id_rs, ex_rd) ||
                          (id_uses_rt && reg_match(id_rt, ex_rd)));

    forwarding_unit u_forwarding_unit (
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .mem_rd       (mem_rd),
        .mem_RegWrite (mem_RegWrite),
        .wb_rd        (wb_rd),
        .wb_RegWrite  (wb_RegWrite),
        .fwd_a        (fwd_a_sel),
        .fwd_b        (fwd_b_sel)
    );

    assign fwd_a     = reset ? FWD_RF : fwd_a_sel;
    assign fwd_b     = reset ? FWD_RF : fwd_b_sel;
    assign unused_ok = ex_RegWrite;
`else
    logic unused_ok;

    // Without forwarding, any writer still in EX or MEM blocks the read.
    // WB is excluded: the register file writes before it is read.
    function automatic logic pending(input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] e_rd,
                                     input logic             e_we,
                                     input logic [REG_W-1:0] m_rd,
                                     input logic             m_we);
        return (e_we && reg_match(src, e_rd)) || (m_we && reg_match(src, m_rd));
    endfunction

    assign data_hazard = pending(id_rs, ex_rd, ex_RegWrite, mem_rd, mem_RegWrite) ||
                         (id_uses_rt &&
                          pending(id_rt, ex_rd, ex_RegWrite, mem_rd, mem_RegWrite));

    assign fwd_a     = FWD_RF;
    assign fwd_b     = FWD_RF;
    assign unused_ok = ^{ex_rs, ex_rt, ex_MemRead, wb_rd, wb_RegWrite};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_RUN;
        else       state <= state_next;
    end

    // Next state and control outputs; memory wait > redirect > data hazard.
    always_comb begin
        ctrl       = '0;
        state_next = state;

        if (mem_wait) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.ifid_stall  = 1'b1;
            ctrl.idex_stall  = 1'b1;
            ctrl.exmem_stall = 1'b1;
            ctrl.memwb_flush = 1'b1;
            state_next       = S_MEMWAIT;
        end else begin
            unique case (state)
                S_RUN, S_MEMWAIT: begin
                    // On the release cycle the held MEM inputs may carry a
                    // redirect that was deferred by the wait; honour it now.
                    if (redirect) begin
                        ctrl.ifid_flush  = 1'b1;
                        ctrl.idex_flush  = 1'b1;
                        ctrl.exmem_flush = 1'b1;
                        state_next       = S_REDIRECT;
                    end else begin
                        state_next = S_RUN;
                        if (state == S_RUN && data_hazard) begin
                            ctrl.pc_stall   = 1'b1;
                            ctrl.ifid_stall = 1'b1;
                            ctrl.idex_flush = 1'b1;
                        end
                    end
                end
                S_REDIRECT: state_next = S_RUN;
                default:    state_next = S_RUN;
            endcase
        end

        // A flush wins over a stall of the same pipeline register.
        if (ctrl.ifid_flush)  ctrl.ifid_stall  = 1'b0;
        if (ctrl.idex_flush)  ctrl.idex_stall  = 1'b0;
        if (ctrl.exmem_flush) ctrl.exmem_stall = 1'b0;
        if (ctrl.memwb_flush) ctrl.memwb_stall = 1'b0;

        if (reset) ctrl = '0;
    end

    assign pc_stall    = ctrl.pc_stall;
    assign ifid_stall  = ctrl.ifid_stall;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_stall  = ctrl.idex_stall;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_stall = ctrl.exmem_stall;
    assign exmem_flush = ctrl.exmem_flush;
    assign memwb_stall = ctrl.memwb_stall;
    assign memwb_flush = ctrl.memwb_flush;

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (reset)                               stall_cnt <= '0;
        else if (ctrl.pc_stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios plus a
// randomized run against a rule-level reference model.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rt, ex_RegWrite, ex_MemRead, mem_RegWrite, wb_RegWrite;
    logic       branch_taken, jump_taken, dmem_req, dmem_ready;
    logic       pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic       exmem_stall, exmem_flush, memwb_stall, memwb_flush;
    logic [1:0] fwd_a, fwd_b;
    logic [15:0] stall_cnt;
    logic [8:0] ctrl;

    int vectors = 0;
    int miscompares = 0;

    // {pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_s, memwb_f}
    localparam logic [8:0] P_NONE = 9'b000000000;
    localparam logic [8:0] P_MW   = 9'b110101001;
    localparam logic [8:0] P_BR   = 9'b001010100;
    localparam logic [8:0] P_HZ   = 9'b110010000;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    always #5 clk = ~clk;

    assign ctrl = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                   exmem_stall, exmem_flush, memwb_stall, memwb_flush};

    hazard_ctrl_unit dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
        .mem_rd(mem_rd), .mem_RegWrite(mem_RegWrite),
        .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite),
        .branch_taken(branch_taken), .jump_taken(jump_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_stall(idex_stall), .idex_flush(idex_flush),
        .exmem_stall(exmem_stall), .exmem_flush(exmem_flush),
        .memwb_stall(memwb_stall), .memwb_flush(memwb_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_uses_rt = 0;
        ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_RegWrite = 0; ex_MemRead = 0;
        mem_rd = 0; mem_RegWrite = 0; wb_rd = 0; wb_RegWrite = 0;
        branch_taken = 0; jump_taken = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // 3 units later, well before the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    // ---------------- reference model ----------------
    bit m_wait, m_redir;
    int m_cnt;

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (!FWD || src == 0)                    return 2'b00;
        if (mem_RegWrite && src == mem_rd)       return 2'b10;
        if (wb_RegWrite && src == wb_rd)         return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit ref_hazard();
        logic [4:0] writers[$];
        logic [4:0] readers[$];
        if (FWD) begin
            if (ex_MemRead) writers.push_back(ex_rd);
        end else begin
            if (ex_RegWrite)  writers.push_back(ex_rd);
            if (mem_RegWrite) writers.push_back(mem_rd);
        end
        readers.push_back(id_rs);
        if (id_uses_rt) readers.push_back(id_rt);
        foreach (readers[r])
            foreach (writers[w])
                if (readers[r] != 0 && readers[r] == writers[w]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [8:0] ref_ctrl();
        bit mw = dmem_req && !dmem_ready;
        bit rd = branch_taken || jump_taken;
        if (reset)   return P_NONE;
        if (mw)      return P_MW;
        if (m_wait)  return rd ? P_BR : P_NONE;
        if (m_redir) return P_NONE;
        if (rd)      return P_BR;
        return ref_hazard() ? P_HZ : P_NONE;
    endfunction

    task automatic model_step(input logic [8:0] exp_ctrl);
        bit mw = dmem_req && !dmem_ready;
        bit rd = branch_taken || jump_taken;
        if (reset) begin
            m_cnt = 0; m_wait = 0; m_redir = 0;
        end else begin
            if (exp_ctrl[8] && m_cnt < 65535) m_cnt = m_cnt + 1;
            m_redir = !mw && rd && !m_redir;
            m_wait  = mw;
        end
    endtask

    // ---------------- directed tests ----------------
    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        dmem_req = 1; branch_taken = 1; id_rs = 3; ex_rd = 3; ex_RegWrite = 1; ex_MemRead = 1;
        ex_rs = 4; mem_rd = 4; mem_RegWrite = 1;
        next_cycle();
        #3;
        vectors++;
        if (ctrl !== P_NONE) begin
            miscompares++;
            $display("FAIL reset_ctrl got=%b want=%b", ctrl, P_NONE);
        end
        vectors++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_fwd got=%b/%b want=00/00", fwd_a, fwd_b);
        end
        vectors++;
        if (stall_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_cnt got=%0d want=0", stall_cnt);
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_data_hazard();
        // {id_rs, id_rt, uses_rt, ex_rd, ex_we, ex_mr, mem_rd, mem_we, wb_rd, wb_we, exp_nofwd, exp_fwd}
        logic [4:0] t_rs[6]  = '{8, 3, 3, 0, 9, 9};
        logic [4:0] t_rt[6]  = '{0, 8, 8, 0, 0, 0};
        bit         t_ut[6]  = '{0, 0, 1, 0, 0, 0};
        logic [4:0] t_erd[6] = '{8, 8, 8, 0, 1, 1};
        bit         t_ewe[6] = '{1, 1, 1, 1, 0, 0};
        bit         t_emr[6] = '{0, 1, 1, 1, 0, 0};
        logic [4:0] t_mrd[6] = '{0, 0, 0, 0, 9, 0};
        bit         t_mwe[6] = '{0, 0, 0, 0, 1, 0};
        logic [4:0] t_wrd[6] = '{0, 0, 0, 0, 0, 9};
        bit         t_wwe[6] = '{0, 0, 0, 0, 0, 1};
        logic [8:0] e_nf[6]  = '{P_HZ, P_NONE, P_HZ, P_NONE, P_HZ, P_NONE};
        logic [8:0] e_f[6]   = '{P_NONE, P_NONE, P_HZ, P_NONE, P_NONE, P_NONE};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            id_rs = t_rs[i]; id_rt = t_rt[i]; id_uses_rt = t_ut[i];
            ex_rd = t_erd[i]; ex_RegWrite = t_ewe[i]; ex_MemRead = t_emr[i];
            mem_rd = t_mrd[i]; mem_RegWrite = t_mwe[i];
            wb_rd = t_wrd[i]; wb_RegWrite = t_wwe[i];
            #3;
            vectors++;
            if (ctrl !== (FWD ? e_f[i] : e_nf[i])) begin
                miscompares++;
                $display("FAIL data_hazard[%0d] got=%b want=%b", i, ctrl, FWD ? e_f[i] : e_nf[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_MemRead = 1; ex_RegWrite = 1; ex_rd = 8; id_rs = 8;
        #3;
        vectors++;
        if (ctrl !== P_HZ) begin
            miscompares++;
            $display("FAIL load_use_stall got=%b want=%b", ctrl, P_HZ);
        end
        next_cycle();
        ex_MemRead = 0; ex_RegWrite = 0; ex_rd = 0;   // bubble now in EX
        #3;
        vectors++;
        if (ctrl !== P_NONE) begin
            miscompares++;
            $display("FAIL load_use_release got=%b want=%b", ctrl, P_NONE);
        end
        next_cycle();
    endtask

    task automatic test_forward();
        do_reset();
        ex_rs = 5; ex_rt = 0; mem_rd = 5; mem_RegWrite = 1; wb_rd = 5; wb_RegWrite = 1;
        #3;
        vectors++;
        if (fwd_a !== (FWD ? 2'b10 : 2'b00) || fwd_b !== 2'b00) begin
            miscompares++;
            $display("FAIL fwd_exmem got=%b/%b want=%b/00", fwd_a, fwd_b, FWD ? 2'b10 : 2'b00);
        end
        next_cycle();
        mem_RegWrite = 0; ex_rt = 5;
        #3;
        vectors++;
        if (fwd_a !== (FWD ? 2'b01 : 2'b00) || fwd_b !== (FWD ? 2'b01 : 2'b00)) begin
            miscompares++;
            $display("FAIL fwd_memwb got=%b/%b want=%b", fwd_a, fwd_b, FWD ? 2'b01 : 2'b00);
        end
        next_cycle();
    endtask

    task automatic test_mem_wait();
        do_reset();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #3;
            vectors++;
            if (ctrl !== P_MW) begin
                miscompares++;
                $display("FAIL mem_wait[%0d] got=%b want=%b", i, ctrl, P_MW);
            end
            next_cycle();
        end
        dmem_ready = 1;
        #3;
        vectors++;
        if (ctrl !== P_NONE) begin
            miscompares++;
            $display("FAIL mem_release got=%b want=%b", ctrl, P_NONE);
        end
        next_cycle();
        clear_inputs();
        #3;
        vectors++;
        if (stall_cnt !== 16'd3) begin
            miscompares++;
            $display("FAIL mem_wait_cnt got=%0d want=3", stall_cnt);
        end
        next_cycle();
    endtask

    task automatic test_branch();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            clear_inputs();
            if (k == 0) branch_taken = 1; else jump_taken = 1;
            #3;
            vectors++;
            if (ctrl !== P_BR) begin
                miscompares++;
                $display("FAIL redirect_flush[%0d] got=%b want=%b", k, ctrl, P_BR);
            end
            next_cycle();
            clear_inputs();
            ex_RegWrite = 1; ex_rd = 7; id_rs = 7;   // hazard ignored in S_REDIRECT
            #3;
            vectors++;
            if (ctrl !== P_NONE) begin
                miscompares++;
                $display("FAIL redirect_shadow[%0d] got=%b want=%b", k, ctrl, P_NONE);
            end
            next_cycle();
            ex_MemRead = 1;                           // back in S_RUN: hazard seen
            #3;
            vectors++;
            if (ctrl !== P_HZ) begin
                miscompares++;
                $display("FAIL redirect_return[%0d] got=%b want=%b", k, ctrl, P_HZ);
            end
            next_cycle();
        end
    endtask

    task automatic test_collision();
        do_reset();
        branch_taken = 1; dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            #3;
            vectors++;
            if (ctrl !== P_MW) begin
                miscompares++;
                $display("FAIL collision_wait[%0d] got=%b want=%b", i, ctrl, P_MW);
            end
            next_cycle();
        end
        dmem_ready = 1;
        #3;
        vectors++;
        if (ctrl !== P_BR) begin
            miscompares++;
            $display("FAIL collision_release got=%b want=%b", ctrl, P_BR);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        dmem_req = 1; dmem_ready = 0;
        next_cycle();
        next_cycle();                 // stall_cnt now nonzero, in S_MEMWAIT
        reset = 1;
        ex_rs = 2; mem_rd = 2; mem_RegWrite = 1;
        #3;
        vectors++;
        if (ctrl !== P_NONE || fwd_a !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_mid_wait_out got=%b fwd=%b want=%b fwd=00", ctrl, fwd_a, P_NONE);
        end
        next_cycle();
        reset = 0;
        clear_inputs();
        ex_RegWrite = 1; ex_MemRead = 1; ex_rd = 0; id_rs = 0;
        #3;
        vectors++;
        if (stall_cnt !== 16'd0 || ctrl !== P_NONE) begin
            miscompares++;
            $display("FAIL reset_mid_wait_cnt got=%0d/%b want=0/%b", stall_cnt, ctrl, P_NONE);
        end
        next_cycle();
        ex_rd = 8; id_rs = 8;         // S_RUN honours the hazard
        #3;
        vectors++;
        if (ctrl !== P_HZ) begin
            miscompares++;
            $display("FAIL reset_mid_wait_run got=%b want=%b", ctrl, P_HZ);
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic [8:0] exp_ctrl;
        do_reset();
        m_wait = 0; m_redir = 0; m_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom_range(0, 39) == 0);
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_uses_rt   = 1'($urandom);
            ex_rs        = 5'($urandom_range(0, 3));
            ex_rt        = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            ex_RegWrite  = 1'($urandom);
            ex_MemRead   = 1'($urandom);
            mem_rd       = 5'($urandom_range(0, 3));
            mem_RegWrite = 1'($urandom);
            wb_rd        = 5'($urandom_range(0, 3));
            wb_RegWrite  = 1'($urandom);
            branch_taken = ($urandom_range(0, 7) == 0);
            jump_taken   = ($urandom_range(0, 9) == 0);
            dmem_req     = ($urandom_range(0, 3) == 0) || m_wait;
            dmem_ready   = 1'($urandom);
            #3;
            exp_ctrl = ref_ctrl();
            vectors++;
            if (ctrl !== exp_ctrl) begin
                miscompares++;
                $display("FAIL rand_ctrl[%0d] got=%b want=%b", i, ctrl, exp_ctrl);
            end
            vectors++;
            if (fwd_a !== (reset ? 2'b00 : ref_fwd(ex_rs)) ||
                fwd_b !== (reset ? 2'b00 : ref_fwd(ex_rt))) begin
                miscompares++;
                $display("FAIL rand_fwd[%0d] got=%b/%b want=%b/%b", i, fwd_a, fwd_b,
                         reset ? 2'b00 : ref_fwd(ex_rs), reset ? 2'b00 : ref_fwd(ex_rt));
            end
            vectors++;
            if (stall_cnt !== 16'(m_cnt)) begin
                miscompares++;
                $display("FAIL rand_cnt[%0d] got=%0d want=%0d", i, stall_cnt, m_cnt);
            end
            model_step(exp_ctrl);
            next_cycle();
        end
        reset = 0;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        test_reset();
        test_data_hazard();
        test_load_use();
        test_forward();
        test_mem_wait();
        test_branch();
        test_collision();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
